// File: rtl/axi_lite_wr_arbiter.sv
// rtl/axi_lite_wr_arbiter.sv - two-master AXI4-Lite write-channel round-robin arbiter
module axi_lite_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                S0_AWVALID,
    output logic                S0_AWREADY,
    input  logic [ADDR_W-1:0]   S0_AWADDR,
    input  logic [2:0]          S0_AWPROT,
    input  logic                S0_WVALID,
    output logic                S0_WREADY,
    input  logic [DATA_W-1:0]   S0_WDATA,
    input  logic [DATA_W/8-1:0] S0_WSTRB,
    output logic                S0_BVALID,
    input  logic                S0_BREADY,
    output logic [1:0]          S0_BRESP,
    input  logic                S1_AWVALID,
    output logic                S1_AWREADY,
    input  logic [ADDR_W-1:0]   S1_AWADDR,
    input  logic [2:0]          S1_AWPROT,
    input  logic                S1_WVALID,
    output logic                S1_WREADY,
    input  logic [DATA_W-1:0]   S1_WDATA,
    input  logic [DATA_W/8-1:0] S1_WSTRB,
    output logic                S1_BVALID,
    input  logic                S1_BREADY,
    output logic [1:0]          S1_BRESP,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [ADDR_W-1:0]   M_AWADDR,
    output logic [2:0]          M_AWPROT,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    input  logic                M_BVALID,
    output logic                M_BREADY,
    input  logic [1:0]          M_BRESP,
    output logic                GRANT,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_DATA = 2'd1,
        ST_RESP      = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q, last_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic in_ad, in_resp;
    logic sel_awvalid, sel_wvalid, sel_bready;
    logic aw_ready_g, w_ready_g, b_valid_g;
    logic aw_fire, w_fire, b_fire;

    assign in_ad   = (state_q == ST_ADDR_DATA);
    assign in_resp = (state_q == ST_RESP);

    assign sel_awvalid = grant_q ? S1_AWVALID : S0_AWVALID;
    assign sel_wvalid  = grant_q ? S1_WVALID  : S0_WVALID;
    assign sel_bready  = grant_q ? S1_BREADY  : S0_BREADY;

    assign M_AWADDR = grant_q ? S1_AWADDR : S0_AWADDR;
    assign M_AWPROT = grant_q ? S1_AWPROT : S0_AWPROT;
    assign M_WDATA  = grant_q ? S1_WDATA  : S0_WDATA;
    assign M_WSTRB  = grant_q ? S1_WSTRB  : S0_WSTRB;

    // Once a channel has handshaken it is masked off so the slave never sees it twice.
    assign M_AWVALID  = in_ad & sel_awvalid & ~aw_done_q;
    assign M_WVALID   = in_ad & sel_wvalid & ~w_done_q;
    assign aw_ready_g = in_ad & M_AWREADY & ~aw_done_q;
    assign w_ready_g  = in_ad & M_WREADY & ~w_done_q;
    assign aw_fire    = M_AWVALID & M_AWREADY;
    assign w_fire     = M_WVALID & M_WREADY;

    assign M_BREADY  = in_resp & sel_bready;
    assign b_valid_g = in_resp & M_BVALID;
    assign b_fire    = b_valid_g & sel_bready;

    assign S0_AWREADY = aw_ready_g & ~grant_q;
    assign S1_AWREADY = aw_ready_g & grant_q;
    assign S0_WREADY  = w_ready_g & ~grant_q;
    assign S1_WREADY  = w_ready_g & grant_q;
    assign S0_BVALID  = b_valid_g & ~grant_q;
    assign S1_BVALID  = b_valid_g & grant_q;
    assign S0_BRESP   = (in_resp & ~grant_q) ? M_BRESP : 2'b00;
    assign S1_BRESP   = (in_resp & grant_q) ? M_BRESP : 2'b00;

    assign GRANT = grant_q;
    assign BUSY  = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (S0_AWVALID | S1_AWVALID) begin
                    // On a tie the master that was not served last goes first.
                    grant_d   = (S0_AWVALID & S1_AWVALID) ? ~last_q : S1_AWVALID;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_ADDR_DATA;
                end
            end
            ST_ADDR_DATA: begin
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_fire) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// tb/tb_axi_lite_wr_arbiter.sv - self-checking bench for axi_lite_wr_arbiter
module tb_axi_lite_wr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_awvalid [2];
    logic          s_wvalid  [2];
    logic          s_bready  [2];
    logic [AW-1:0] s_awaddr  [2];
    logic [2:0]    s_awprot  [2];
    logic [DW-1:0] s_wdata   [2];
    logic [SW-1:0] s_wstrb   [2];

    logic s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
    logic [1:0] s0_bresp, s1_bresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [AW-1:0] m_awaddr;
    logic [2:0]    m_awprot;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [1:0]    m_bresp;
    logic grant, busy;

    axi_lite_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(clk), .ARESET(rst),
        .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s0_awready), .S0_AWADDR(s_awaddr[0]),
        .S0_AWPROT(s_awprot[0]), .S0_WVALID(s_wvalid[0]), .S0_WREADY(s0_wready),
        .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_BVALID(s0_bvalid),
        .S0_BREADY(s_bready[0]), .S0_BRESP(s0_bresp),
        .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s1_awready), .S1_AWADDR(s_awaddr[1]),
        .S1_AWPROT(s_awprot[1]), .S1_WVALID(s_wvalid[1]), .S1_WREADY(s1_wready),
        .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_BVALID(s1_bvalid),
        .S1_BREADY(s_bready[1]), .S1_BRESP(s1_bresp),
        .M_AWVALID(m_awvalid), .M_AWREADY(m_awready), .M_AWADDR(m_awaddr),
        .M_AWPROT(m_awprot), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_BVALID(m_bvalid),
        .M_BREADY(m_bready), .M_BRESP(m_bresp),
        .GRANT(grant), .BUSY(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic awready_of(input int n);
        return (n == 0) ? s0_awready : s1_awready;
    endfunction
    function automatic logic wready_of(input int n);
        return (n == 0) ? s0_wready : s1_wready;
    endfunction
    function automatic logic bvalid_of(input int n);
        return (n == 0) ? s0_bvalid : s1_bvalid;
    endfunction
    function automatic logic [1:0] bresp_of(input int n);
        return (n == 0) ? s0_bresp : s1_bresp;
    endfunction

    // Transaction-level model: who owns the slave, which channels are still owed, whether
    // the response phase has begun, and who was served last.
    int md_owner = -1;
    bit md_aw_owed, md_w_owed, md_resp;
    bit md_last = 1'b1;
    bit md_known = 1'b0;
    int model_log[$];
    int dut_log[$];

    always @(negedge clk) begin
        bit xfer, rsp, e_awv, e_wv, r0, r1;
        int o;
        xfer = (md_owner >= 0) && !md_resp;
        rsp  = (md_owner >= 0) && md_resp;
        o    = (md_owner < 0) ? 0 : md_owner;
        if (md_known) begin
            e_awv = xfer && md_aw_owed && s_awvalid[o];
            e_wv  = xfer && md_w_owed && s_wvalid[o];
            chk("busy", busy, 64'(md_owner >= 0));
            if (md_owner >= 0) chk("grant", grant, 64'(o));
            chk("m_awvalid", m_awvalid, 64'(e_awv));
            chk("m_wvalid", m_wvalid, 64'(e_wv));
            chk("m_bready", m_bready, 64'(rsp && s_bready[o]));
            for (int k = 0; k < 2; k++) begin
                chk("s_awready", awready_of(k), 64'(xfer && k == o && md_aw_owed && m_awready));
                chk("s_wready", wready_of(k), 64'(xfer && k == o && md_w_owed && m_wready));
                chk("s_bvalid", bvalid_of(k), 64'(rsp && k == o && m_bvalid));
                if (rsp && k == o) chk("s_bresp_own", bresp_of(k), 64'(m_bresp));
                else if (md_owner < 0 || k != o) chk("s_bresp_idle", bresp_of(k), 64'd0);
            end
            if (e_awv) begin
                chk("m_awaddr", m_awaddr, 64'(s_awaddr[o]));
                chk("m_awprot", m_awprot, 64'(s_awprot[o]));
            end
            if (e_wv) begin
                chk("m_wdata", m_wdata, 64'(s_wdata[o]));
                chk("m_wstrb", m_wstrb, 64'(s_wstrb[o]));
            end
        end
        if (s0_bvalid === 1'b1 && s_bready[0]) dut_log.push_back(0);
        if (s1_bvalid === 1'b1 && s_bready[1]) dut_log.push_back(1);

        if (rst) begin
            md_owner = -1;
            md_last  = 1'b1;
            md_known = 1'b1;
        end else if (md_owner < 0) begin
            r0 = s_awvalid[0];
            r1 = s_awvalid[1];
            if (r0 || r1) begin
                md_owner   = (r0 && r1) ? (md_last ? 0 : 1) : (r1 ? 1 : 0);
                md_aw_owed = 1'b1;
                md_w_owed  = 1'b1;
                md_resp    = 1'b0;
            end
        end else if (!md_resp) begin
            if (md_aw_owed && s_awvalid[o] && m_awready) md_aw_owed = 1'b0;
            if (md_w_owed && s_wvalid[o] && m_wready) md_w_owed = 1'b0;
            if (!md_aw_owed && !md_w_owed) md_resp = 1'b1;
        end else if (m_bvalid && s_bready[o]) begin
            model_log.push_back(o);
            md_last  = (o == 1);
            md_owner = -1;
        end
    end

    logic [AW-1:0] cap_addr  [2];
    logic [DW-1:0] cap_data  [2];
    logic [1:0]    cap_bresp [2];
    logic          cap_grant [2];
    int            cap_aw_cyc[2];
    int            cap_w_cyc [2];

    task automatic mwrite(input int n, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int w_lead, output int ncyc);
        bit awh, wh, bh, rs;
        int k;
        s_awaddr[n] = addr;
        s_awprot[n] = addr[4:2];
        s_wdata[n]  = data;
        s_wstrb[n]  = strb;
        ncyc = 0;
        if (w_lead > 0) begin
            s_wvalid[n] = 1'b1;
            repeat (w_lead) @(posedge clk);
            #1;
        end
        s_awvalid[n] = 1'b1;
        s_wvalid[n]  = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            awh = s_awvalid[n] && awready_of(n) === 1'b1;
            wh  = s_wvalid[n] && wready_of(n) === 1'b1;
            bh  = s_bready[n] && bvalid_of(n) === 1'b1;
            rs  = rst;
            if (awh) begin cap_addr[n] = m_awaddr; cap_grant[n] = grant; cap_aw_cyc[n] = cyc; end
            if (wh) begin cap_data[n] = m_wdata; cap_w_cyc[n] = cyc; end
            if (bh) cap_bresp[n] = bresp_of(n);
            @(posedge clk);
            #1;
            ncyc++;
            if (awh) s_awvalid[n] = 1'b0;
            if (wh) s_wvalid[n] = 1'b0;
            if (rs) begin
                s_awvalid[n] = 1'b0;
                s_wvalid[n]  = 1'b0;
                break;
            end
            if (bh) break;
        end
        if (k == 200) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout master %0d: no B response within 200 cycles", n);
        end
    endtask

    task automatic chk_order(input string nm, input int exp_q[$]);
        chk({nm, "_count"}, 64'(dut_log.size()), 64'(exp_q.size()));
        chk({nm, "_model_count"}, 64'(model_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dut_log.size(); i++)
            chk({nm, "_owner"}, 64'(dut_log[i]), 64'(exp_q[i]));
        for (int i = 0; i < exp_q.size() && i < model_log.size(); i++)
            chk({nm, "_model_owner"}, 64'(model_log[i]), 64'(exp_q[i]));
        dut_log.delete();
        model_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int c0, c1, t0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_awvalid[i] = 1'b0; s_wvalid[i] = 1'b0; s_bready[i] = 1'b1;
            s_awaddr[i] = '0; s_awprot[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0;
        end
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_bready", m_bready, 0);
        chk("rst_s0_bvalid", s0_bvalid, 0);
        @(posedge clk);
        #1;

        mwrite(0, 32'h1000, 32'hDEADBEEF, 4'hF, 0, c0);
        chk("t1_cycles", c0, 3);
        chk("t1_awaddr", cap_addr[0], 32'h1000);
        chk("t1_wdata", cap_data[0], 32'hDEADBEEF);
        chk("t1_bresp", cap_bresp[0], 0);
        chk("t1_grant", cap_grant[0], 0);
        chk_order("t1", '{0});

        do_reset();
        fork
            mwrite(0, 32'h0100, 32'h11111111, 4'h1, 0, c0);
            mwrite(1, 32'h0200, 32'h22222222, 4'h2, 0, c1);
        join
        chk("t2_s0_cycles", c0, 3);
        chk("t2_s1_cycles", c1, 6);
        chk("t2_s1_grant", cap_grant[1], 1);
        fork
            mwrite(0, 32'h0104, 32'h33333333, 4'h4, 0, c0);
            mwrite(1, 32'h0204, 32'h44444444, 4'h8, 0, c1);
        join
        chk("t2_third_s0_cycles", c0, 3);
        chk_order("t2", '{0, 1, 0, 1});

        m_awready = 1'b0;
        fork
            mwrite(1, 32'h2000, 32'h12345678, 4'h3, 2, c1);
            begin repeat (6) @(posedge clk); #1; m_awready = 1'b1; end
        join
        chk("t3_cycles", c1, 6);
        chk("t3_aw_after_w", 64'(cap_aw_cyc[1] - cap_w_cyc[1]), 3);
        chk("t3_awaddr", cap_addr[1], 32'h2000);
        chk_order("t3", '{1});

        m_bresp = 2'b10;
        s_bready[0] = 1'b0;
        fork
            mwrite(0, 32'h4000, 32'hCAFEF00D, 4'hC, 0, c0);
            begin @(posedge clk); #1; mwrite(1, 32'h5000, 32'h0BADCAFE, 4'h6, 0, c1); end
            begin repeat (6) @(posedge clk); #1; s_bready[0] = 1'b1; end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("t4_s0_bvalid_held", s0_bvalid, 1);
                chk("t4_s0_bresp_held", s0_bresp, 2'b10);
                chk("t4_s1_awready", s1_awready, 0);
                chk("t4_grant", grant, 0);
            end
        join
        chk("t4_s0_cycles", c0, 7);
        chk("t4_s0_bresp", cap_bresp[0], 2'b10);
        chk_order("t4", '{0, 1});
        m_bresp = 2'b00;

        m_bvalid = 1'b0;
        fork
            mwrite(1, 32'h3000, 32'h55AA55AA, 4'hF, 0, c1);
            begin repeat (3) @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1; rst = 1'b0; end
        join
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_grant", grant, 0);
        chk("t5_m_awvalid", m_awvalid, 0);
        chk("t5_m_bready", m_bready, 0);
        chk("t5_s1_bvalid", s1_bvalid, 0);
        chk_order("t5_abandon", '{});
        m_bvalid = 1'b1;
        @(posedge clk);
        #1;
        fork
            mwrite(0, 32'h6000, 32'h01020304, 4'h5, 0, c0);
            mwrite(1, 32'h7000, 32'h05060708, 4'hA, 0, c1);
        join
        chk("t5_s0_cycles", c0, 3);
        chk_order("t5", '{0, 1});

        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            mwrite(0, 32'h8000 + 32'(i * 4), 32'hA0000000 + 32'(i), 4'hF, 0, c0);
            chk("t6_cycles", c0, 3);
        end
        chk("t6_total_cycles", 64'(cyc - t0), 9);
        chk_order("t6", '{0, 0, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
